// File: rtl/mul_fu_iter_pkg.sv
// Shared types for the iterative multiply functional unit: branch tags,
// mul_type encodings, FSM states and the branch-flush kill rule.
package mul_fu_iter_pkg;

  localparam int BR_TAG_W = 3;

  typedef struct packed {
    logic                sign;
    logic [BR_TAG_W-1:0] tag;
  } branch_tag_t;

  localparam logic [1:0] MUL_SS = 2'b00;
  localparam logic [1:0] MUL_SU = 2'b01;
  localparam logic [1:0] MUL_UU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // True when an op speculated under `tag` is squashed by a flush of `flush_tag`.
  function automatic logic br_tag_killed(input branch_tag_t tag, input branch_tag_t flush_tag);
    if (tag.sign == flush_tag.sign)
      return (tag.tag & flush_tag.tag) == flush_tag.tag;
    else
      return (tag.tag & flush_tag.tag) == tag.tag;
  endfunction

endpackage

// File: rtl/mul_unsigned_iter.sv
// Unsigned shift-add multiplier for 33-bit magnitudes: retires BITS_PER_CYCLE
// multiplier bits per cycle into a 64-bit accumulator after a start pulse.
module mul_unsigned_iter #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [32:0] mcand,
  input  logic [32:0] mplier,
  output logic        last,
  output logic [63:0] product_next
);

  localparam int ITER  = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);

  logic [63:0]               acc;
  logic [63:0]               mcand_sh;
  logic [32:0]               mplier_sh;
  logic [CNT_W-1:0]          count;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [63:0]               partial;

  // Magnitudes never exceed 2^32-1, so the low 32 multiplier bits suffice.
  always_comb begin
    digit   = mplier_sh[BITS_PER_CYCLE-1:0];
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (digit[i]) partial = partial + (mcand_sh << i);
    end
    product_next = acc + partial;
    last         = (count == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      count     <= '0;
    end else if (abort) begin
      count <= '0;
    end else if (start) begin
      acc       <= '0;
      mcand_sh  <= {31'b0, mcand};
      mplier_sh <= mplier;
      count     <= CNT_W'(ITER);
    end else if (count != '0) begin
      acc       <= product_next;
      mcand_sh  <= mcand_sh << BITS_PER_CYCLE;
      mplier_sh <= mplier_sh >> BITS_PER_CYCLE;
      count     <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mul_fu_iter.sv
// Iterative MUL/MULH/MULHSU/MULHU functional unit with CDB req/grant and flush.
// Optional MUL_ZERO_SKIP_EN: a zero operand completes one cycle after issue.
module mul_fu_iter
  import mul_fu_iter_pkg::*;
#(
  parameter int ROB_WIDTH      = 3,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  branch_tag_t          flush_tag,
  input  logic                 issue,
  input  logic [31:0]          operand1,
  input  logic [31:0]          operand2,
  input  logic [1:0]           mul_type,
  input  logic                 upper,
  input  branch_tag_t          br_tag_in,
  input  logic [ROB_WIDTH-1:0] dest_ROB_in,
  output logic                 running,
  output logic                 cdb_req,
  input  logic                 cdb_grant,
  output logic [31:0]          rd_v,
  output logic [ROB_WIDTH-1:0] dest_ROB_out,
  output branch_tag_t          br_tag_out
);

  // Handshake: the result is offered while cdb_req is high and is consumed on
  // the cycle cdb_req & cdb_grant are both high; a killing flush overrides grant.

  mul_state_e  state, state_next;
  logic        neg_q, upper_q;
  logic        accept, kill_held, zero_skip;
  logic        sign1, sign2;
  logic [32:0] op1_ext, op2_ext, mag1, mag2;
  logic        mul_start, mul_abort, mul_last;
  logic [63:0] mul_product_next, prod_signed;
  logic [31:0] result;

`ifdef MUL_ZERO_SKIP_EN
  assign zero_skip = (operand1 == 32'd0) || (operand2 == 32'd0);
`else
  assign zero_skip = 1'b0;
`endif

  always_comb begin
    sign1   = (mul_type == MUL_SS) || (mul_type == MUL_SU);
    sign2   = (mul_type == MUL_SS);
    op1_ext = {sign1 & operand1[31], operand1};
    op2_ext = {sign2 & operand2[31], operand2};
    mag1    = op1_ext[32] ? (~op1_ext + 33'd1) : op1_ext;
    mag2    = op2_ext[32] ? (~op2_ext + 33'd1) : op2_ext;

    accept    = (state == ST_IDLE) && issue && !(flush && br_tag_killed(br_tag_in, flush_tag));
    kill_held = flush && br_tag_killed(br_tag_out, flush_tag);
    mul_start = accept && !zero_skip;
    mul_abort = (state != ST_IDLE) && kill_held;

    prod_signed = neg_q ? (~mul_product_next + 64'd1) : mul_product_next;
    result      = upper_q ? prod_signed[63:32] : prod_signed[31:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = zero_skip ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (kill_held)     state_next = ST_IDLE;
        else if (mul_last) state_next = ST_DONE;
      end
      ST_DONE: if (kill_held || cdb_grant) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rd_v         <= '0;
      dest_ROB_out <= '0;
      br_tag_out   <= '0;
      neg_q        <= 1'b0;
      upper_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        dest_ROB_out <= dest_ROB_in;
        br_tag_out   <= br_tag_in;
        upper_q      <= upper;
        neg_q        <= op1_ext[32] ^ op2_ext[32];
        if (zero_skip) rd_v <= '0;
      end
      if ((state == ST_CALC) && mul_last && !kill_held) rd_v <= result;
    end
  end

  assign running = (state != ST_IDLE);
  assign cdb_req = (state == ST_DONE);

  mul_unsigned_iter #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .abort        (mul_abort),
    .mcand        (mag1),
    .mplier       (mag2),
    .last         (mul_last),
    .product_next (mul_product_next)
  );

endmodule

// File: tb/tb_mul_fu_iter.sv
// Directed bench for mul_fu_iter: product values, latency, CDB hold, flush, reset.
module tb_mul_fu_iter;
  import mul_fu_iter_pkg::*;

`ifdef MUL_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 17;
`endif
  localparam int FULL_LAT = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  branch_tag_t flush_tag = '0;
  logic        issue = 1'b0;
  logic [31:0] operand1 = '0, operand2 = '0;
  logic [1:0]  mul_type = '0;
  logic        upper = 1'b0;
  branch_tag_t br_tag_in = '0;
  logic [2:0]  dest_ROB_in = '0;
  logic        running, cdb_req;
  logic        cdb_grant = 1'b0;
  logic [31:0] rd_v;
  logic [2:0]  dest_ROB_out;
  branch_tag_t br_tag_out;

  int n_cmp = 0;
  int n_bad = 0;

  mul_fu_iter #(.ROB_WIDTH(3), .BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_tag(flush_tag), .issue(issue),
    .operand1(operand1), .operand2(operand2), .mul_type(mul_type), .upper(upper),
    .br_tag_in(br_tag_in), .dest_ROB_in(dest_ROB_in), .running(running),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .rd_v(rd_v),
    .dest_ROB_out(dest_ROB_out), .br_tag_out(br_tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge; returns #1 after the edge that samples issue.
  task automatic drive_issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mt,
                             input logic up, input branch_tag_t tg, input logic [2:0] rob);
    issue = 1'b1; operand1 = a; operand2 = b; mul_type = mt; upper = up;
    br_tag_in = tg; dest_ROB_in = rob;
    step();
    issue = 1'b0;
  endtask

  // Counts cycles since issue until cdb_req rises, bounded; running must stay high.
  task automatic wait_req(input int start_cyc, output int cyc);
    int low_run;
    low_run = 0;
    cyc = start_cyc;
    while (!cdb_req && cyc < 60) begin
      if (!running) low_run++;
      step();
      cyc++;
    end
    check("running_while_busy", 64'(low_run), 64'd0);
  endtask

  task automatic grant_and_check(input string nm, input logic [31:0] exp_v,
                                 input branch_tag_t tg, input logic [2:0] rob, input int hold);
    for (int i = 0; i < hold; i++) begin
      check({nm, "_hold_rd_v"}, 64'(rd_v), 64'(exp_v));
      check({nm, "_hold_dest"}, 64'(dest_ROB_out), 64'(rob));
      check({nm, "_hold_tag"}, {60'b0, br_tag_out}, {60'b0, tg});
      check({nm, "_hold_run"}, 64'({running, cdb_req}), 64'd3);
      step();
    end
    check({nm, "_rd_v"}, 64'(rd_v), 64'(exp_v));
    check({nm, "_dest"}, 64'(dest_ROB_out), 64'(rob));
    check({nm, "_tag"}, {60'b0, br_tag_out}, {60'b0, tg});
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    check({nm, "_idle_after_grant"}, 64'({running, cdb_req}), 64'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mt;
    logic        up;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int cyc, lat, req_seen;
    branch_tag_t tg;

    vecs[0]  = '{32'd7,        32'hFFFFFFFD, 2'b00, 1'b0, 32'hFFFFFFEB};
    vecs[1]  = '{32'd7,        32'hFFFFFFFD, 2'b00, 1'b1, 32'hFFFFFFFF};
    vecs[2]  = '{32'h80000000, 32'h80000000, 2'b00, 1'b1, 32'h40000000};
    vecs[3]  = '{32'h80000000, 32'h80000000, 2'b00, 1'b0, 32'h00000000};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b1, 32'hFFFFFFFE};
    vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h00000001};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1'b1, 32'hFFFFFFFF};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h00000001};
    vecs[8]  = '{32'hFFFFFFFF, 32'd2,        2'b11, 1'b1, 32'h00000001};
    vecs[9]  = '{32'hFFFFFFFB, 32'hFFFFFFFA, 2'b00, 1'b0, 32'h0000001E};
    vecs[10] = '{32'hFFFFFFFB, 32'hFFFFFFFA, 2'b00, 1'b1, 32'h00000000};
    vecs[11] = '{32'h80000000, 32'd2,        2'b01, 1'b1, 32'hFFFFFFFF};
    vecs[12] = '{32'h80000000, 32'h7FFFFFFF, 2'b00, 1'b1, 32'hC0000000};
    vecs[13] = '{32'h80000000, 32'h7FFFFFFF, 2'b00, 1'b0, 32'h80000000};
    vecs[14] = '{32'd0,        32'h00001234, 2'b00, 1'b0, 32'h00000000};

    // Reset state, checked while rst is still asserted.
    #1;
    check("rst_running", 64'(running), 64'd0);
    check("rst_cdb_req", 64'(cdb_req), 64'd0);
    check("rst_rd_v", 64'(rd_v), 64'd0);
    check("rst_dest", 64'(dest_ROB_out), 64'd0);
    check("rst_tag", {60'b0, br_tag_out}, 64'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Back-to-back directed vectors; vector 0 holds grant off for 5 cycles.
    for (int i = 0; i < 15; i++) begin
      tg = '{sign: 1'b0, tag: 3'(i)};
      drive_issue(vecs[i].a, vecs[i].b, vecs[i].mt, vecs[i].up, tg, 3'(i + 1));
      wait_req(1, cyc);
      lat = ((vecs[i].a == 0) || (vecs[i].b == 0)) ? ZERO_LAT : FULL_LAT;
      check($sformatf("v%0d_latency", i), 64'(cyc), 64'(lat));
      grant_and_check($sformatf("v%0d", i), vecs[i].exp, tg, 3'(i + 1), (i == 0) ? 5 : 0);
    end

    // Killing flush in CALC cycle 5 (same sign, flush tag covered by op tag).
    tg = '{sign: 1'b0, tag: 3'b011};
    drive_issue(32'd3, 32'd5, 2'b00, 1'b0, tg, 3'd2);
    step(); step(); step(); step();
    flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 3'b001};
    step();
    flush = 1'b0;
    check("kill_calc_idle", 64'({running, cdb_req}), 64'd0);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (cdb_req) req_seen++;
      step();
    end
    check("kill_calc_no_req", 64'(req_seen), 64'd0);

    // Non-matching flush in CALC cycle 5: op completes normally.
    drive_issue(32'd3, 32'd5, 2'b00, 1'b0, tg, 3'd2);
    step(); step(); step(); step();
    flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 3'b100};
    step();
    flush = 1'b0;
    check("nokill_running", 64'(running), 64'd1);
    wait_req(6, cyc);
    check("nokill_latency", 64'(cyc), 64'd17);
    grant_and_check("nokill", 32'd15, tg, 3'd2, 0);

    // Opposite-sign flush whose tag covers the op tag.
    tg = '{sign: 1'b0, tag: 3'b001};
    drive_issue(32'd9, 32'd9, 2'b10, 1'b0, tg, 3'd4);
    step(); step();
    flush = 1'b1; flush_tag = '{sign: 1'b1, tag: 3'b011};
    step();
    flush = 1'b0;
    check("kill_sign_idle", 64'({running, cdb_req}), 64'd0);

    // Killing flush coincident with issue: op dropped.
    flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 3'b001};
    drive_issue(32'd9, 32'd9, 2'b10, 1'b0, '{sign: 1'b0, tag: 3'b011}, 3'd5);
    flush = 1'b0;
    check("kill_issue_idle", 64'({running, cdb_req}), 64'd0);

    // Killing flush in DONE with grant high: result withdrawn.
    tg = '{sign: 1'b0, tag: 3'b111};
    drive_issue(32'd6, 32'd7, 2'b00, 1'b0, tg, 3'd6);
    wait_req(1, cyc);
    check("done_kill_latency", 64'(cyc), 64'd17);
    cdb_grant = 1'b1; flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 3'b010};
    step();
    cdb_grant = 1'b0; flush = 1'b0;
    check("done_kill_idle", 64'({running, cdb_req}), 64'd0);

    // Recovery op after the kills.
    tg = '{sign: 1'b1, tag: 3'b000};
    drive_issue(32'd6, 32'd7, 2'b00, 1'b0, tg, 3'd7);
    wait_req(1, cyc);
    check("recover_latency", 64'(cyc), 64'd17);
    grant_and_check("recover", 32'd42, tg, 3'd7, 0);

    // Asynchronous reset mid-operation.
    drive_issue(32'd11, 32'd13, 2'b00, 1'b0, tg, 3'd3);
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("midrst_running", 64'({running, cdb_req}), 64'd0);
    check("midrst_rd_v", 64'(rd_v), 64'd0);
    check("midrst_dest", 64'(dest_ROB_out), 64'd0);
    check("midrst_tag", {60'b0, br_tag_out}, 64'd0);
    step();
    rst = 1'b0;
    step();
    tg = '{sign: 1'b0, tag: 3'b010};
    drive_issue(32'd11, 32'd13, 2'b00, 1'b0, tg, 3'd3);
    wait_req(1, cyc);
    check("postrst_latency", 64'(cyc), 64'd17);
    grant_and_check("postrst", 32'd143, tg, 3'd3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_fu_iter.md
Name: mul_fu_iter

Overview:
- Multi-cycle iterative integer multiplier; the functional unit directly downstream of the multiply reservation station.
- Accepts one issued MUL/MULH/MULHSU/MULHU op per `issue` pulse.
- Raises `running` to block further issue, computes the product over several cycles, and arbitrates for the CDB with a req/grant handshake.
- Discards in-flight work on a branch flush whose tag covers the op.

Parameters:
- ROB_WIDTH, 3, width of ROB index.
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration (legal: 1, 2, 4); ITER = 32/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  branch mispredict flush strobe
- flush_tag  in  branch_tag_t  tag of mispredicted branch
- issue  in  1  RS issues op this cycle
- operand1  in  32  rs1 value
- operand2  in  32  rs2 value
- mul_type  in  2  00 signed×signed, 01 signed×unsigned, 10/11 unsigned×unsigned
- upper  in  1  1 = product[63:32], 0 = product[31:0]
- br_tag_in  in  branch_tag_t  speculation tag of op
- dest_ROB_in  in  ROB_WIDTH  destination ROB entry
- running  out  1  FU busy; RS must not issue while high
- cdb_req  out  1  result valid, requesting CDB
- cdb_grant  in  1  CDB accepts result this cycle
- rd_v  out  32  result
- dest_ROB_out  out  ROB_WIDTH  ROB entry of result
- br_tag_out  out  branch_tag_t  tag of held op

Behaviour:
- Reset (async, rst=1): state IDLE; running=0, cdb_req=0, rd_v=0, dest_ROB_out=0, br_tag_out='0; accumulator and counter cleared.
- States:
  - IDLE (running=0).
  - CALC (running=1).
  - DONE (running=1, cdb_req=1).
- IDLE + issue:
  - Latch tag, dest ROB, and upper.
  - Compute operand signs per mul_type: operand1 signed if mul_type∈{00,01}; operand2 signed if mul_type==00.
  - Store magnitudes, plus neg = sign1 XOR sign2.
  - Counter = ITER; go to CALC.
- CALC:
  - Each cycle add (multiplicand << shift) × next BITS_PER_CYCLE multiplier bits into the 64-bit unsigned accumulator; decrement counter.
  - On last iteration: negate the 64-bit product if neg, select half per upper, register into rd_v; go to DONE.
- Latency: cdb_req first high exactly ITER+1 cycles after the issue cycle (17 at default).
- DONE:
  - Hold rd_v, dest_ROB_out, and br_tag_out stable while cdb_req=1 and cdb_grant=0.
  - cdb_req & cdb_grant → IDLE next cycle; running falls the same edge.
  - Earliest next issue is the cycle after grant.
- `running` is a registered function of state only; there is no combinational path from `issue` or `cdb_grant`.
- Flush kill rule, evaluated on the held br_tag_out (or on br_tag_in during the accept cycle). Op is killed iff:
  - sign equal and (tag & flush_tag.tag)==flush_tag.tag, or
  - sign differs and (tag & flush_tag.tag)==tag.
- flush & kill in CALC or DONE: next state IDLE, cdb_req low next cycle, no CDB write.
  - This holds even if cdb_grant is high the same cycle: grant is ignored, and the arbiter must not latch a killed result.
- flush & kill coincident with issue in IDLE: op dropped, stay IDLE.
- flush & no kill: no effect.
- Arithmetic edge cases:
  - 0x80000000 magnitude handled as 33-bit unsigned (no overflow).
  - Negation is 64-bit two's complement.
  - Results match RISC-V M spec for all operand values.
- rst asserted mid-operation: immediate return to reset values; in-flight op lost.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined: on accept, if either operand is zero, go directly to DONE with rd_v=0 next cycle (cdb_req 1 cycle after issue).
- Undefined: all ops take the full ITER+1 latency.

Decomposition:
- rv32i_types additions:
  - mul_type encoding constants (MUL_SS=2'b00, MUL_SU=2'b01, MUL_UU=2'b10).
  - A function br_tag_killed(tag, flush_tag) implementing the kill rule, shared with reservation stations.
- Sub-module mul_unsigned_iter: 33×33 unsigned shift-add datapath with start/done and accumulator.
- The FU wrapper owns sign handling, the FSM, the CDB handshake, and flush.

Test Plan:
- mul_type=00, upper=0, operand1=7, operand2=0xFFFFFFFD → rd_v=0xFFFFFFEB, dest_ROB_out=issued value, cdb_req at issue+17, running high cycles 1..grant.
- mul_type=00, upper=1, 0x80000000×0x80000000 → 0x40000000; upper=0 → 0x00000000.
- mul_type=10, 0xFFFFFFFF×0xFFFFFFFF → upper 0xFFFFFFFE, lower 0x00000001; mul_type=01 same operands upper → 0xFFFFFFFF.
- cdb_grant held low 5 cycles after cdb_req → rd_v/dest/tag stable, running=1; grant → IDLE, new issue accepted next cycle.
- flush in CALC cycle 5 with killing tag → running=0 next cycle, cdb_req never rises; repeat with non-matching tag → normal result at issue+17.
- With MUL_ZERO_SKIP_EN: 0×0x1234 → rd_v=0, cdb_req at issue+1; without the macro → cdb_req at issue+17.
